fifo_serial_tx: RTL and testbench

- Draining end of the 16-entry peripheral FIFO. Pops bytes from the FIFO read port and serialises each one as an asynchronous 8N1-style frame on a single TX line.
- Sits between the FIFO read side (rdreq/empty/q, where q is show-ahead and valid whenever empty=0) and the board TX pin.
- One frame is sent at a time, with no internal storage beyond the shift register.

---
 rtl/fifo_serial_pkg.sv | 13 +
 rtl/baud_tick_gen.sv | 40 ++++
 rtl/fifo_serial_tx.sv | 117 +++++++++++
 tb/tb_fifo_serial_tx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_serial_pkg.sv
// rtl/fifo_serial_pkg.sv - shared state encoding and line constants for fifo_serial_tx
package fifo_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic TXD_IDLE = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period counter, ticks on the last cycle of each bit
module baud_tick_gen #(
    parameter int clks_per_bit = 16
) (
    input  logic clock,
    input  logic sclr,
    input  logic run,
    output logic tick
);

    localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count 0..clks_per_bit-1 while running; held at zero while idle so every frame starts aligned
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - pops bytes from a show-ahead FIFO and sends them as 8N1 frames
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int data_width   = 8,
    parameter int clks_per_bit = 16
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_q,
    output logic                  fifo_rdreq,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BW = $clog2(data_width + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(data_width - 1);

    state_t                state_q;
    state_t                state_d;
    logic [data_width-1:0] shift_q;
    logic [data_width-1:0] shift_d;
    logic [BW-1:0]         bit_cnt_q;
    logic [BW-1:0]         bit_cnt_d;
    logic                  txd_q;
    logic                  txd_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  run;
    logic                  tick;

    assign run = (state_q != ST_IDLE);

    baud_tick_gen #(
        .clks_per_bit(clks_per_bit)
    ) u_baud (
        .clock(clock),
        .sclr (sclr),
        .run  (run),
        .tick (tick)
    );

    // Pop only from IDLE; gated by sclr so no pop escapes while reset is held
    assign fifo_rdreq = (state_q == ST_IDLE) && enable && !fifo_empty && !sclr;

    // Frame sequencing; txd is computed one cycle ahead so the line comes straight from a flop
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_q;
        case (state_q)
            ST_IDLE: begin
                txd_d = TXD_IDLE;
                if (fifo_rdreq) begin
                    shift_d = fifo_q;
                    state_d = ST_START;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    txd_d     = shift_d[0];
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        txd_d   = TXD_IDLE;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    txd_d   = TXD_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = TXD_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops the line high and discards the byte in flight
    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= TXD_IDLE;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign tx_done = (state_q == ST_STOP) && tick;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - randomized self-checking bench for fifo_serial_tx
module tb_fifo_serial_tx;

    logic       clock = 1'b0;
    logic       sclr_a = 1'b1;
    logic       sclr_b = 1'b1;
    logic       enable_a = 1'b0;
    logic       enable_b = 1'b0;
    logic       empty_a, empty_b;
    logic [7:0] q_a, q_b;
    logic       rdreq_a, rdreq_b;
    logic       txd_a, txd_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    int         wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    int         pop_cyc_a [$];
    int         pop_cyc_b [$];
    int         pops [2];
    int         frames [2];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    fifo_serial_tx #(.data_width(8), .clks_per_bit(4)) dut_a (
        .clock(clock), .sclr(sclr_a), .enable(enable_a), .fifo_empty(empty_a), .fifo_q(q_a),
        .fifo_rdreq(rdreq_a), .txd(txd_a), .busy(busy_a), .tx_done(done_a)
    );

    fifo_serial_tx #(.data_width(8), .clks_per_bit(2)) dut_b (
        .clock(clock), .sclr(sclr_b), .enable(enable_b), .fifo_empty(empty_b), .fifo_q(q_b),
        .fifo_rdreq(rdreq_b), .txd(txd_b), .busy(busy_b), .tx_done(done_b)
    );

    // Show-ahead FIFO models: the bench owns the write pointers, the pop edge owns the read pointers
    assign empty_a = (wr_a == rd_a);
    assign empty_b = (wr_b == rd_b);
    assign q_a     = mem_a[rd_a[3:0]];
    assign q_b     = mem_b[rd_b[3:0]];

    always @(posedge clock) begin
        if (rdreq_a) rd_a <= rd_a + 1;
        if (rdreq_b) rd_b <= rd_b + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic get_rd(input int sel);
        return (sel == 0) ? rdreq_a : rdreq_b;
    endfunction
    function automatic logic get_empty(input int sel);
        return (sel == 0) ? empty_a : empty_b;
    endfunction
    function automatic logic get_sclr(input int sel);
        return (sel == 0) ? sclr_a : sclr_b;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int sel, input logic [7:0] d);
        if (sel == 0) begin
            mem_a[wr_a[3:0]] = d;
            wr_a++;
            exp_a.push_back(d);
        end else begin
            mem_b[wr_b[3:0]] = d;
            wr_b++;
            exp_b.push_back(d);
        end
    endtask

    // Reference: each pop must be followed by start bit, 8 data bits LSB first, stop bit, one idle cycle
    task automatic monitor(input int sel);
        int          cpb;
        int          len;
        bit          skip;
        bit          aborted;
        logic [7:0]  b;
        logic [63:0] v_txd, v_busy, v_done, v_rd, e_txd;
        string       p;
        cpb  = (sel == 0) ? 4 : 2;
        len  = 10 * cpb;
        p    = (sel == 0) ? "a" : "b";
        skip = 0;
        forever begin
            if (!skip) @(negedge clock);
            skip = 0;
            if (get_rd(sel)) begin
                check_eq({p, "_rd_nonempty"}, get_empty(sel), 1'b0);
                pops[sel]++;
                if (sel == 0) pop_cyc_a.push_back(cyc);
                else          pop_cyc_b.push_back(cyc);
                b = 8'h00;
                if (sel == 0 && exp_a.size() > 0)      b = exp_a.pop_front();
                else if (sel == 1 && exp_b.size() > 0) b = exp_b.pop_front();
                else check_eq({p, "_exp_avail"}, 0, 1);
                v_txd = '0; v_busy = '0; v_done = '0; v_rd = '0; aborted = 0;
                for (int k = 0; k < len; k++) begin
                    @(negedge clock);
                    if (get_sclr(sel)) aborted = 1;
                    v_txd[k]  = (sel == 0) ? txd_a  : txd_b;
                    v_busy[k] = (sel == 0) ? busy_a : busy_b;
                    v_done[k] = (sel == 0) ? done_a : done_b;
                    v_rd[k]   = get_rd(sel);
                end
                @(negedge clock);
                if (get_sclr(sel)) aborted = 1;
                if (!aborted) begin
                    e_txd = '0;
                    for (int k = 0; k < len; k++) begin
                        int bp;
                        bp = k / cpb;
                        if (bp == 0)      e_txd[k] = 1'b0;
                        else if (bp == 9) e_txd[k] = 1'b1;
                        else              e_txd[k] = b[bp-1];
                    end
                    check_eq({p, "_frame_txd"},  v_txd,  e_txd);
                    check_eq({p, "_frame_busy"}, v_busy, (64'd1 << len) - 64'd1);
                    check_eq({p, "_frame_done"}, v_done, 64'd1 << (len - 1));
                    check_eq({p, "_frame_rdreq"}, v_rd,  64'd0);
                    check_eq({p, "_idle_txd"},  (sel == 0) ? txd_a  : txd_b,  1'b1);
                    check_eq({p, "_idle_busy"}, (sel == 0) ? busy_a : busy_b, 1'b0);
                    check_eq({p, "_idle_done"}, (sel == 0) ? done_a : done_b, 1'b0);
                end
                frames[sel]++;
                skip = 1;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_frames(input int sel, input int target, input string tag);
        int guard;
        guard = 0;
        while (frames[sel] < target && guard < 3000) begin
            step(1);
            guard++;
        end
        check_eq(tag, frames[sel], target);
    endtask

    initial begin
        int f0, base, n_rd, n_low;
        logic [7:0] r1, r2;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end

        // Reset state
        step(1);
        check_eq("rst_txd",   txd_a,   1'b1);
        check_eq("rst_busy",  busy_a,  1'b0);
        check_eq("rst_done",  done_a,  1'b0);
        check_eq("rst_rdreq", rdreq_a, 1'b0);
        check_eq("rst_txd_b", txd_b,   1'b1);
        sclr_a = 1'b0;
        sclr_b = 1'b0;
        step(2);

        // Enabled with an empty FIFO: nothing moves
        enable_a = 1'b1;
        n_rd = 0; n_low = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (rdreq_a) n_rd++;
            if (!txd_a)  n_low++;
        end
        check_eq("empty_rdreq", n_rd, 0);
        check_eq("empty_txd_low", n_low, 0);

        // Single byte 0xA5
        f0 = frames[0];
        push(0, 8'hA5);
        wait_frames(0, f0 + 1, "single_frames");
        check_eq("single_pops", pops[0], 1);

        // Back-to-back frames
        f0 = frames[0];
        base = pop_cyc_a.size();
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        wait_frames(0, f0 + 3, "b2b_frames");
        for (int i = 1; i < 3; i++)
            check_eq("b2b_period", pop_cyc_a[base+i] - pop_cyc_a[base+i-1], 41);
        check_eq("b2b_empty", empty_a, 1'b1);

        // enable dropped mid-frame: frame completes, no further pop until re-enabled
        f0 = frames[0];
        base = pops[0];
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        push(0, r1);
        push(0, r2);
        step(10);
        enable_a = 1'b0;
        wait_frames(0, f0 + 1, "endrop_frames");
        step(60);
        check_eq("endrop_pops", pops[0], base + 1);
        check_eq("endrop_level", wr_a - rd_a, 1);
        enable_a = 1'b1;
        #1;
        check_eq("reenable_rdreq", rdreq_a, 1'b1);
        wait_frames(0, f0 + 2, "reenable_frames");

        // Reset during DATA: line high at once, byte discarded, resume from IDLE
        f0 = frames[0];
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        push(0, r1);
        step(20);
        check_eq("rst_mid_pre_busy", busy_a, 1'b1);
        push(0, r2);
        #2;
        sclr_a = 1'b1;
        #1;
        check_eq("rst_mid_txd",   txd_a,   1'b1);
        check_eq("rst_mid_busy",  busy_a,  1'b0);
        check_eq("rst_mid_rdreq", rdreq_a, 1'b0);
        n_rd = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (rdreq_a) n_rd++;
        end
        check_eq("rst_hold_rdreq", n_rd, 0);
        sclr_a = 1'b0;
        #1;
        check_eq("rst_resume_rdreq", rdreq_a, 1'b1);
        wait_frames(0, f0 + 2, "rst_resume_frames");
        check_eq("rst_resume_empty", empty_a, 1'b1);

        // Full FIFO drain: 16 bytes, 16 pops, fixed period
        f0 = frames[0];
        base = pop_cyc_a.size();
        n_rd = pops[0];
        enable_a = 1'b0;
        for (int i = 0; i < 16; i++) push(0, 8'(i));
        check_eq("full_level", wr_a - rd_a, 16);
        enable_a = 1'b1;
        wait_frames(0, f0 + 16, "full_frames");
        check_eq("full_pops", pops[0] - n_rd, 16);
        for (int i = 1; i < 16; i++)
            check_eq("full_period", pop_cyc_a[base+i] - pop_cyc_a[base+i-1], 41);
        check_eq("full_empty", empty_a, 1'b1);

        // Random bytes with random gaps
        f0 = frames[0];
        for (int i = 0; i < 5; i++) begin
            push(0, 8'($urandom));
            step($urandom_range(0, 50));
        end
        wait_frames(0, f0 + 5, "rand_frames");
        check_eq("rand_empty", empty_a, 1'b1);

        // Minimum divider on the second instance
        push(1, 8'h81);
        push(1, 8'($urandom));
        push(1, 8'($urandom));
        enable_b = 1'b1;
        wait_frames(1, 3, "min_frames");
        for (int i = 1; i < 3; i++)
            check_eq("min_period", pop_cyc_b[i] - pop_cyc_b[i-1], 21);
        check_eq("min_pops", pops[1], 3);
        check_eq("min_empty", empty_b, 1'b1);

        step(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
